// File: rtl/tmds_rx_decoder.sv
// ============================================================================
// tmds_rx_decoder : TMDS receive channel: word alignment by control-token
//                   search, then 10b->8b decode into data/DE/control outputs.
// Optional: TMDS_RX_ERRCNT_EN adds clr_err_i / err_cnt_o lock-loss counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tmds_rx_decoder #(
  parameter int LOCK_COUNT  = 8,
  parameter int SEARCH_WAIT = 64,
  parameter int LOSS_WINDOW = 4096
) (
  input  logic        px_clk_i,
  input  logic        rst_ni,
`ifdef TMDS_RX_ERRCNT_EN
  input  logic        clr_err_i,
  output logic [15:0] err_cnt_o,
`endif
  input  logic [9:0]  raw_i,
  output logic [7:0]  data_o,
  output logic        de_o,
  output logic [1:0]  c_o,
  output logic        locked_o,
  output logic [3:0]  offset_o
);

  localparam int TW = $clog2(LOCK_COUNT) + 1;
  localparam int WW = $clog2(SEARCH_WAIT) + 1;
  localparam int LW = $clog2(LOSS_WINDOW) + 1;
  localparam logic [TW-1:0] TOK_LAST  = TW'(LOCK_COUNT - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(SEARCH_WAIT - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_WINDOW - 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [9:0]      raw_q;
  logic [9:0]      sym;
  logic            flush;
  logic [TW-1:0]   tok_cnt, tok_n;
  logic [WW-1:0]   wait_cnt, wait_n;
  logic [LW-1:0]   loss_cnt, loss_n;
  logic            slip;
  logic            is_token;
  logic [1:0]      code;
  logic [7:0]      dmask;
  logic [7:0]      decoded;
  logic [19:0]     win_shift;

  assign win_shift = {raw_i, raw_q} >> offset_o;

  always_comb begin
    is_token = 1'b1;
    code     = 2'b00;
    case (sym)
      10'b1101010100: code = 2'b00;
      10'b0010101011: code = 2'b01;
      10'b0101010100: code = 2'b10;
      10'b1010101011: code = 2'b11;
      default:        is_token = 1'b0;
    endcase
  end

  always_comb begin
    dmask      = sym[9] ? ~sym[7:0] : sym[7:0];
    decoded    = '0;
    decoded[0] = dmask[0];
    for (int i = 1; i < 8; i++) begin
      decoded[i] = sym[8] ? (dmask[i] ^ dmask[i-1]) : ~(dmask[i] ^ dmask[i-1]);
    end
  end

  // A symbol registered in the same edge as an offset slip used the old
  // offset, so the cycle after a slip is ignored entirely.
  always_comb begin
    state_n = state;
    tok_n   = tok_cnt;
    wait_n  = wait_cnt;
    loss_n  = loss_cnt;
    slip    = 1'b0;
    if (!flush) begin
      case (state)
        SEARCH: begin
          if (is_token) begin
            state_n = VERIFY;
            tok_n   = TW'(1);
            wait_n  = '0;
          end else if (wait_cnt == WAIT_LAST) begin
            slip   = 1'b1;
            wait_n = '0;
          end else begin
            wait_n = wait_cnt + 1'b1;
          end
        end
        VERIFY: begin
          if (is_token) begin
            if (tok_cnt == TOK_LAST) begin
              state_n = LOCKED;
              tok_n   = '0;
              loss_n  = '0;
            end else begin
              tok_n = tok_cnt + 1'b1;
            end
          end else begin
            state_n = SEARCH;
            tok_n   = '0;
            wait_n  = '0;
          end
        end
        LOCKED: begin
          if (is_token) begin
            loss_n = '0;
          end else if (loss_cnt == LOSS_LAST) begin
            state_n = SEARCH;
            loss_n  = '0;
            wait_n  = '0;
            slip    = 1'b1;
          end else begin
            loss_n = loss_cnt + 1'b1;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  always_ff @(posedge px_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= SEARCH;
      raw_q    <= '0;
      sym      <= '0;
      flush    <= 1'b0;
      tok_cnt  <= '0;
      wait_cnt <= '0;
      loss_cnt <= '0;
      offset_o <= '0;
      locked_o <= 1'b0;
      data_o   <= '0;
      de_o     <= 1'b0;
      c_o      <= '0;
    end else begin
      state    <= state_n;
      raw_q    <= raw_i;
      sym      <= win_shift[9:0];
      flush    <= slip;
      tok_cnt  <= tok_n;
      wait_cnt <= wait_n;
      loss_cnt <= loss_n;
      locked_o <= (state_n == LOCKED);
      if (slip) begin
        offset_o <= (offset_o == 4'd9) ? 4'd0 : offset_o + 4'd1;
      end
      if (state == LOCKED) begin
        if (is_token) begin
          de_o   <= 1'b0;
          c_o    <= code;
          data_o <= '0;
        end else begin
          de_o   <= 1'b1;
          data_o <= decoded;
        end
      end else begin
        de_o   <= 1'b0;
        data_o <= '0;
        c_o    <= '0;
      end
    end
  end

`ifdef TMDS_RX_ERRCNT_EN
  logic lost;
  assign lost = (state == LOCKED) && (state_n == SEARCH);

  always_ff @(posedge px_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_o <= '0;
    end else if (clr_err_i) begin
      err_cnt_o <= '0;
    end else if (lost && (err_cnt_o != 16'hFFFF)) begin
      err_cnt_o <= err_cnt_o + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_tmds_rx_decoder.sv
// Bench for tmds_rx_decoder: serialises symbols at a chosen bit delay and
// compares every cycle against a behavioural channel model.
`default_nettype none

module tb_tmds_rx_decoder;

  localparam logic [9:0] T0 = 10'b1101010100;
  localparam logic [9:0] T1 = 10'b0010101011;
  localparam logic [9:0] T2 = 10'b0101010100;
  localparam logic [9:0] T3 = 10'b1010101011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  raw = '0;
  logic [7:0]  data;
  logic        de;
  logic [1:0]  c;
  logic        locked;
  logic [3:0]  offset;
  logic        clr = 1'b0;
`ifdef TMDS_RX_ERRCNT_EN
  logic [15:0] err;
`endif

  int checks = 0;
  int errors = 0;

  int         delay = 0;
  logic [9:0] prev_s = '0;

  // behavioural model state
  logic [9:0] m_rawq, m_sym;
  bit         m_flush;
  int         m_mode;   // 0 search, 1 verify, 2 locked
  int         m_wait, m_tok, m_loss, m_off;
  logic [7:0] m_data;
  logic       m_de, m_locked;
  logic [1:0] m_c;
  int         m_err;

  tmds_rx_decoder dut (
    .px_clk_i (clk),
    .rst_ni   (rst_n),
`ifdef TMDS_RX_ERRCNT_EN
    .clr_err_i(clr),
    .err_cnt_o(err),
`endif
    .raw_i    (raw),
    .data_o   (data),
    .de_o     (de),
    .c_o      (c),
    .locked_o (locked),
    .offset_o (offset)
  );

  always #5 clk = ~clk;

  function automatic int classify(input logic [9:0] s);
    if (s == T0) return 0;
    if (s == T1) return 1;
    if (s == T2) return 2;
    if (s == T3) return 3;
    return -1;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] d, o;
    d    = s[9] ? ~s[7:0] : s[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rawq = '0; m_sym = '0; m_flush = 0; m_mode = 0;
    m_wait = 0; m_tok = 0; m_loss = 0; m_off = 0;
    m_data = '0; m_de = 0; m_c = '0; m_locked = 0; m_err = 0;
  endtask

  task automatic model_edge(input logic [9:0] r, input logic cl);
    int         code;
    bit         slip, lost;
    logic [19:0] w;
    code = classify(m_sym);
    w    = {r, m_rawq} >> m_off;
    slip = 0;
    lost = 0;
    if (m_mode == 2) begin
      if (code >= 0) begin m_de = 0; m_c = 2'(code); m_data = '0; end
      else begin m_de = 1; m_data = decode(m_sym); end
    end else begin
      m_de = 0; m_c = '0; m_data = '0;
    end
    if (m_flush) m_flush = 0;
    else if (m_mode == 0) begin
      if (code >= 0) begin m_mode = 1; m_tok = 1; m_wait = 0; end
      else if (m_wait == 63) begin slip = 1; m_wait = 0; end
      else m_wait++;
    end else if (m_mode == 1) begin
      if (code < 0) begin m_mode = 0; m_tok = 0; m_wait = 0; end
      else if (m_tok + 1 == 8) begin m_mode = 2; m_tok = 0; m_loss = 0; end
      else m_tok++;
    end else begin
      if (code >= 0) m_loss = 0;
      else if (m_loss == 4095) begin lost = 1; slip = 1; m_mode = 0; m_loss = 0; m_wait = 0; end
      else m_loss++;
    end
    if (slip) begin m_off = (m_off + 1) % 10; m_flush = 1; end
    m_locked = (m_mode == 2);
    if (cl) m_err = 0;
    else if (lost && m_err < 16'hFFFF) m_err++;
    m_sym  = w[9:0];
    m_rawq = r;
  endtask

  task automatic step(input logic [9:0] r);
    raw = r;
    @(posedge clk);
    model_edge(r, clr);
    #1;
    chk("data", data, m_data);
    chk("de", de, m_de);
    chk("c", c, m_c);
    chk("locked", locked, m_locked);
    chk("offset", offset, m_off);
`ifdef TMDS_RX_ERRCNT_EN
    chk("err_cnt", err, m_err);
`endif
  endtask

  task automatic send_sym(input logic [9:0] s);
    logic [19:0] tmp;
    tmp = ({10'b0, s} << delay) | ({10'b0, prev_s} >> (10 - delay));
    prev_s = s;
    step(tmp[9:0]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      raw = 10'($urandom);
      @(posedge clk); #1;
      chk("rst_data", data, 0);
      chk("rst_de", de, 0);
      chk("rst_c", c, 0);
      chk("rst_locked", locked, 0);
      chk("rst_offset", offset, 0);
    end
    raw   = '0;
    rst_n = 1'b1;
  endtask

  task automatic lock_on(input logic [9:0] tok, input int bound, input string tag);
    for (int i = 0; i < bound && !locked; i++) send_sym(tok);
    chk(tag, locked, 1);
  endtask

  initial begin
    int         slips;
    logic [3:0] last_off;
    logic [9:0] s;

    // reset and idle
    do_reset();
    for (int i = 0; i < 4; i++) step(10'h000);
    chk("idle_de", de, 0);
    chk("idle_locked", locked, 0);

    // broken verification run at zero delay
    delay = 0;
    repeat (5) send_sym(T0);
    send_sym(10'h100);
    repeat (9) send_sym(T0);
    chk("verify_break_not_locked", locked, 0);
    send_sym(T0);
    chk("verify_break_locked", locked, 1);
    chk("verify_break_offset", offset, 0);

    // alignment search over a stream delayed by 3 bits
    do_reset();
    delay = 3; prev_s = T0;
    slips = 0; last_off = 0;
    for (int i = 0; i < 400 && !locked; i++) begin
      send_sym(T0);
      if (offset != last_off) begin
        slips++;
        chk("align_step", offset, last_off + 4'd1);
        last_off = offset;
      end
    end
    chk("align_locked", locked, 1);
    chk("align_offset", offset, 3);
    chk("align_slips", slips, 3);
    send_sym(T0); send_sym(T0);
    chk("align_c", c, 0);
    chk("align_de", de, 0);

    // decode while locked
    repeat (3) send_sym(10'h100);
    chk("dec_100_de", de, 1);
    chk("dec_100_data", data, 8'h00);
    repeat (3) send_sym(10'h200);
    chk("dec_200_data", data, 8'hFF);
    repeat (3) send_sym(T1);
    chk("tok01_de", de, 0);
    chk("tok01_c", c, 1);
    chk("tok01_data", data, 0);
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0: s = T0;
        1: s = T1;
        2: s = T2;
        3: s = T3;
        default: s = 10'($urandom);
      endcase
      send_sym(s);
    end
    chk("random_locked", locked, 1);

    // lock at offset 9, then loss timing and wrap
    do_reset();
    delay = 9; prev_s = T0;
    lock_on(T0, 1000, "lock9_reached");
    chk("lock9_offset", offset, 9);
    repeat (4) send_sym(T0);
    repeat (4095) send_sym(10'h100);
    send_sym(T2);
    repeat (2) send_sym(T2);
    chk("loss_token_keeps_lock", locked, 1);
    chk("loss_token_c", c, 2);
    repeat (4098) send_sym(10'h100);
    chk("loss_unlocked", locked, 0);
    chk("loss_wrap_offset", offset, 0);

`ifdef TMDS_RX_ERRCNT_EN
    chk("errcnt_one", err, 1);
    delay = 0;
    lock_on(T3, 60, "relock0");
    repeat (4) send_sym(T3);
    repeat (4098) send_sym(10'h100);
    chk("errcnt_two", err, 2);
    chk("loss2_offset", offset, 1);
    delay = 1;
    lock_on(T0, 60, "relock1");
    repeat (4) send_sym(T0);
    repeat (4090) send_sym(10'h100);
    clr = 1'b1;
    repeat (10) send_sym(10'h100);
    clr = 1'b0;
    repeat (2) send_sym(10'h100);
    chk("errcnt_cleared", err, 0);
    chk("loss3_unlocked", locked, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
